sc_road_sequencer: RTL and testbench

- Game-flow controller for the RoadFighter display path; sequences the seven 2-bit row-mux selects that feed the display muxes.
- Waits for START, scrolls randomly generated road/obstacle rows downward on the game time base, and freezes on collision or level completion.
- Shows a blink pattern for game-over and a solid pattern for a win.
- Sits between the prescaler/random generator and the seven row muxes.

---
 rtl/sc_roadseq_pkg.sv | 29 ++
 rtl/sc_row_shifter.sv | 56 +++++
 rtl/sc_road_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_sc_road_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_roadseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_roadseq_pkg
//  Description : Shared state encodings, row select codes and geometry for
//                the RoadFighter road sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_roadseq_pkg;

  // Game-flow states; encodings 5..7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    PLAY = 3'd2,
    OVER = 3'd3,
    WIN  = 3'd4
  } state_e;

  // Row mux select codes.
  localparam logic [1:0] SEL_BLANK = 2'd0;
  localparam logic [1:0] SEL_ROAD  = 2'd1;
  localparam logic [1:0] SEL_OBST  = 2'd2;
  localparam logic [1:0] SEL_FLASH = 2'd3;

  // Number of display rows driven by the sequencer.
  localparam int ROWS = 7;

endpackage : sc_roadseq_pkg
`default_nettype wire

// File: rtl/sc_row_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : sc_row_shifter
//  Description : ROWS-deep shift register of row select codes. Row 0 is the
//                top row; shifting moves every row one place downward.
//                Priority: clear, then force-all, then shift.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_row_shifter
  import sc_roadseq_pkg::*;
#(
  parameter int SELWIDTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_clear,
  input  logic                               i_shift_en,
  input  logic [SELWIDTH-1:0]                i_serial,
  input  logic                               i_force_en,
  input  logic [SELWIDTH-1:0]                i_force_val,
  output logic [ROWS-1:0][SELWIDTH-1:0]      o_rows
);

  logic [ROWS-1:0][SELWIDTH-1:0] rows_q;
  logic [ROWS-1:0][SELWIDTH-1:0] rows_d;

  // Next row contents: clear wins over force, force wins over a scroll shift.
  always_comb begin
    rows_d = rows_q;
    if (i_clear) begin
      rows_d = '0;
    end else if (i_force_en) begin
      for (int r = 0; r < ROWS; r++) begin
        rows_d[r] = i_force_val;
      end
    end else if (i_shift_en) begin
      rows_d[0] = i_serial;
      for (int r = 1; r < ROWS; r++) begin
        rows_d[r] = rows_q[r-1];
      end
    end
  end

  // Row storage with synchronous reset to blank.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q <= '0;
    end else begin
      rows_q <= rows_d;
    end
  end

  assign o_rows = rows_q;

endmodule : sc_row_shifter
`default_nettype wire

// File: rtl/sc_road_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sc_road_sequencer
//  Description : Game-flow controller for the RoadFighter display path. Waits
//                for START, scrolls random road rows on the game time base,
//                freezes on collision (blinking flash) or level completion
//                (solid road), and drives the seven row mux selects.
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_road_sequencer
  import sc_roadseq_pkg::*;
#(
  parameter int SELWIDTH       = 2,
  parameter int TICKS_PER_STEP = 4,
  parameter int LEVEL_STEPS    = 16,
  parameter int BLINK_TICKS    = 2
) (
  input  logic                SC_ROADSEQ_CLOCK_50,
  input  logic                SC_ROADSEQ_RESET_InHigh,
  input  logic                SC_ROADSEQ_START_InLow,
  input  logic                SC_ROADSEQ_TICK_InHigh,
  input  logic [SELWIDTH-1:0] SC_ROADSEQ_RANDOM_InBUS,
  input  logic                SC_ROADSEQ_COLLISION_InHigh,
  output logic [SELWIDTH-1:0] SC_ROADSEQ_SIGNAL_OUT_1,
  output logic [SELWIDTH-1:0] SC_ROADSEQ_SIGNAL_OUT_2,
  output logic [SELWIDTH-1:0] SC_ROADSEQ_SIGNAL_OUT_3,
  output logic [SELWIDTH-1:0] SC_ROADSEQ_SIGNAL_OUT_4,
  output logic [SELWIDTH-1:0] SC_ROADSEQ_SIGNAL_OUT_5,
  output logic [SELWIDTH-1:0] SC_ROADSEQ_SIGNAL_OUT_6,
  output logic [SELWIDTH-1:0] SC_ROADSEQ_SIGNAL_OUT_7,
  output logic [2:0]          SC_ROADSEQ_STATE_OutBUS,
  output logic [7:0]          SC_ROADSEQ_PROGRESS_OutBUS
);

  localparam logic [3:0] C_TICK_LAST  = 4'(TICKS_PER_STEP - 1);
  localparam logic [3:0] C_BLINK_LAST = 4'(BLINK_TICKS - 1);
  localparam logic [7:0] C_LEVEL      = 8'(LEVEL_STEPS);

  localparam logic [SELWIDTH-1:0] C_SEL_BLANK = SELWIDTH'(SEL_BLANK);
  localparam logic [SELWIDTH-1:0] C_SEL_ROAD  = SELWIDTH'(SEL_ROAD);
  localparam logic [SELWIDTH-1:0] C_SEL_FLASH = SELWIDTH'(SEL_FLASH);

  wire clk = SC_ROADSEQ_CLOCK_50;
  wire rst = SC_ROADSEQ_RESET_InHigh;

  state_e      state_q,     state_d;
  logic        start_q;
  logic [3:0]  tick_cnt_q,  tick_cnt_d;
  logic [3:0]  blink_cnt_q, blink_cnt_d;
  logic        phase_q,     phase_d;
  logic [7:0]  progress_q,  progress_d;

  logic                          w_start_ev;
  logic                          w_step;
  logic [7:0]                    w_progress_inc;
  logic [SELWIDTH-1:0]           w_serial;
  logic                          w_row_clear;
  logic                          w_row_shift;
  logic                          w_row_force_en;
  logic [SELWIDTH-1:0]           w_row_force_val;
  logic [ROWS-1:0][SELWIDTH-1:0] w_rows;

  // A press is the registered high-to-low edge of the active-low button.
  assign w_start_ev     = start_q & ~SC_ROADSEQ_START_InLow;
  assign w_progress_inc = progress_q + 8'd1;

  // The flash code never enters the road; it is replaced by plain road.
  assign w_serial = (SC_ROADSEQ_RANDOM_InBUS == C_SEL_FLASH) ? C_SEL_ROAD
                                                             : SC_ROADSEQ_RANDOM_InBUS;

  // Next-state, counter and progress logic for the game flow.
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    progress_d  = progress_q;
    w_step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_start_ev) state_d = ARM;
      end
      ARM: begin
        tick_cnt_d  = 4'd0;
        blink_cnt_d = 4'd0;
        progress_d  = 8'd0;
        // The arming tick only releases play; it is not counted.
        if (SC_ROADSEQ_TICK_InHigh) state_d = PLAY;
      end
      PLAY: begin
        // Collision pre-empts any step landing in the same cycle.
        if (SC_ROADSEQ_COLLISION_InHigh) begin
          state_d     = OVER;
          blink_cnt_d = 4'd0;
          phase_d     = 1'b1;
        end else if (SC_ROADSEQ_TICK_InHigh) begin
          if (tick_cnt_q == C_TICK_LAST) begin
            tick_cnt_d = 4'd0;
            w_step     = 1'b1;
            progress_d = w_progress_inc;
            if (w_progress_inc == C_LEVEL) state_d = WIN;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      OVER: begin
        if (w_start_ev) begin
          state_d = IDLE;
        end else if (SC_ROADSEQ_TICK_InHigh) begin
          if (blink_cnt_q == C_BLINK_LAST) begin
            blink_cnt_d = 4'd0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 4'd1;
          end
        end
      end
      WIN: begin
        if (w_start_ev) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Row control follows the state being entered so the rows always match STATE.
  always_comb begin
    w_row_clear     = 1'b0;
    w_row_shift     = 1'b0;
    w_row_force_en  = 1'b0;
    w_row_force_val = C_SEL_BLANK;
    case (state_d)
      PLAY: begin
        w_row_shift = w_step;
      end
      OVER: begin
        w_row_force_en  = 1'b1;
        w_row_force_val = phase_d ? C_SEL_FLASH : C_SEL_BLANK;
      end
      WIN: begin
        w_row_force_en  = 1'b1;
        w_row_force_val = C_SEL_ROAD;
      end
      default: begin
        w_row_clear = 1'b1;
      end
    endcase
  end

  // FSM state, counters, blink phase, progress and start edge register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      start_q     <= 1'b1;
      tick_cnt_q  <= 4'd0;
      blink_cnt_q <= 4'd0;
      phase_q     <= 1'b1;
      progress_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      start_q     <= SC_ROADSEQ_START_InLow;
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      progress_q  <= progress_d;
    end
  end

  sc_row_shifter #(
    .SELWIDTH (SELWIDTH)
  ) u_row_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_row_clear),
    .i_shift_en  (w_row_shift),
    .i_serial    (w_serial),
    .i_force_en  (w_row_force_en),
    .i_force_val (w_row_force_val),
    .o_rows      (w_rows)
  );

  assign SC_ROADSEQ_SIGNAL_OUT_1    = w_rows[0];
  assign SC_ROADSEQ_SIGNAL_OUT_2    = w_rows[1];
  assign SC_ROADSEQ_SIGNAL_OUT_3    = w_rows[2];
  assign SC_ROADSEQ_SIGNAL_OUT_4    = w_rows[3];
  assign SC_ROADSEQ_SIGNAL_OUT_5    = w_rows[4];
  assign SC_ROADSEQ_SIGNAL_OUT_6    = w_rows[5];
  assign SC_ROADSEQ_SIGNAL_OUT_7    = w_rows[6];
  assign SC_ROADSEQ_STATE_OutBUS    = state_q;
  assign SC_ROADSEQ_PROGRESS_OutBUS = progress_q;

endmodule : sc_road_sequencer
`default_nettype wire

// File: tb/tb_sc_road_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_road_sequencer
//  Description : Self-checking bench for sc_road_sequencer: directed game
//                scenarios followed by random traffic, all compared against
//                a behavioural game model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sc_road_sequencer;

  localparam int SELWIDTH = 2;
  localparam int TPS      = 4;
  localparam int LEVEL    = 16;
  localparam int BT       = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_n;
  logic       tick;
  logic       coll;
  logic [1:0] rnd;
  logic [1:0] o1, o2, o3, o4, o5, o6, o7;
  logic [2:0] st;
  logic [7:0] prog;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sc_road_sequencer #(
    .SELWIDTH       (SELWIDTH),
    .TICKS_PER_STEP (TPS),
    .LEVEL_STEPS    (LEVEL),
    .BLINK_TICKS    (BT)
  ) dut (
    .SC_ROADSEQ_CLOCK_50         (clk),
    .SC_ROADSEQ_RESET_InHigh     (rst),
    .SC_ROADSEQ_START_InLow      (start_n),
    .SC_ROADSEQ_TICK_InHigh      (tick),
    .SC_ROADSEQ_RANDOM_InBUS     (rnd),
    .SC_ROADSEQ_COLLISION_InHigh (coll),
    .SC_ROADSEQ_SIGNAL_OUT_1     (o1),
    .SC_ROADSEQ_SIGNAL_OUT_2     (o2),
    .SC_ROADSEQ_SIGNAL_OUT_3     (o3),
    .SC_ROADSEQ_SIGNAL_OUT_4     (o4),
    .SC_ROADSEQ_SIGNAL_OUT_5     (o5),
    .SC_ROADSEQ_SIGNAL_OUT_6     (o6),
    .SC_ROADSEQ_SIGNAL_OUT_7     (o7),
    .SC_ROADSEQ_STATE_OutBUS     (st),
    .SC_ROADSEQ_PROGRESS_OutBUS  (prog)
  );

  // ---------------- behavioural game model ----------------
  // States: 0 idle, 1 arm, 2 play, 3 game over, 4 win.
  int m_state = 0;
  int m_prog  = 0;
  int m_ticks = 0;   // ticks seen in the current step
  int m_blink = 0;   // ticks seen in the current blink half-period
  bit m_on    = 1'b1;
  bit m_btn   = 1'b1;
  int m_rows[7];

  task automatic fill(input int v);
    for (int r = 0; r < 7; r++) m_rows[r] = v;
  endtask

  // Advance the model by one clock using the inputs held during that cycle.
  task automatic model_step();
    bit pressed;
    pressed = m_btn && !start_n;
    if (rst) begin
      m_state = 0; m_prog = 0; m_ticks = 0; m_blink = 0; m_on = 1'b1; m_btn = 1'b1;
      fill(0);
      return;
    end
    m_btn = start_n;
    case (m_state)
      0: begin
        if (pressed) m_state = 1;
        fill(0);
      end
      1: begin
        m_prog = 0; m_ticks = 0; m_blink = 0;
        if (tick) m_state = 2;
        fill(0);
      end
      2: begin
        if (coll) begin
          m_state = 3; m_blink = 0; m_on = 1'b1;
          fill(3);
        end else if (tick) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == TPS) begin
            m_ticks = 0;
            for (int r = 6; r > 0; r--) m_rows[r] = m_rows[r-1];
            m_rows[0] = (rnd == 2'd3) ? 1 : int'(rnd);
            m_prog = m_prog + 1;
            if (m_prog == LEVEL) begin
              m_state = 4;
              fill(1);
            end
          end
        end
      end
      3: begin
        if (pressed) begin
          m_state = 0;
          fill(0);
        end else begin
          if (tick) begin
            m_blink = m_blink + 1;
            if (m_blink == BT) begin
              m_blink = 0;
              m_on = !m_on;
            end
          end
          fill(m_on ? 3 : 0);
        end
      end
      default: begin
        if (pressed) begin
          m_state = 0;
          fill(0);
        end else begin
          fill(1);
        end
      end
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},    st,   m_state);
    chk({tag, ".progress"}, prog, m_prog);
    chk({tag, ".out1"}, o1, m_rows[0]);
    chk({tag, ".out2"}, o2, m_rows[1]);
    chk({tag, ".out3"}, o3, m_rows[2]);
    chk({tag, ".out4"}, o4, m_rows[3]);
    chk({tag, ".out5"}, o5, m_rows[4]);
    chk({tag, ".out6"}, o6, m_rows[5]);
    chk({tag, ".out7"}, o7, m_rows[6]);
  endtask

  // One clock: model follows the DUT edge, then outputs are compared 1ns later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  // A tick pulse followed by a quiet cycle.
  task automatic tick_once(input string tag, input logic [1:0] r);
    rnd = r; tick = 1'b1;
    cycle(tag);
    tick = 1'b0;
    cycle(tag);
  endtask

  task automatic press(input string tag);
    start_n = 1'b0;
    cycle(tag);
    start_n = 1'b1;
    cycle(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int arm_entries;
    logic [2:0] prev_st;
    logic [1:0] seq [3];
    seq[0] = 2'd2; seq[1] = 2'd1; seq[2] = 2'd3;

    fill(0);
    rst = 1'b1; start_n = 1'b1; tick = 1'b0; coll = 1'b0; rnd = 2'd0;
    cycle("reset");
    cycle("reset");
    rst = 1'b0;
    chk("reset_state", st, 0);
    chk("reset_progress", prog, 0);
    cycle("idle");

    // Held button: exactly one ARM entry, tick moves to PLAY, no re-arm.
    arm_entries = 0;
    prev_st = st;
    start_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) tick = 1'b1;
      cycle("held_start");
      tick = 1'b0;
      if (st == 3'd1 && prev_st != 3'd1) arm_entries++;
      prev_st = st;
    end
    start_n = 1'b1;
    cycle("release");
    chk("arm_entries", arm_entries, 1);
    chk("held_play", st, 2);

    // Three steps with RANDOM 2,1,3 on successive steps.
    for (int i = 0; i < 12; i++) tick_once("scroll", seq[i / 4]);
    chk("scroll_out1", o1, 1);
    chk("scroll_out2", o2, 1);
    chk("scroll_out3", o3, 2);
    chk("scroll_progress", prog, 3);

    // Two more steps, then reset mid-play.
    for (int i = 0; i < 8; i++) tick_once("scroll2", 2'($urandom));
    chk("pre_reset_progress", prog, 5);
    rst = 1'b1;
    cycle("mid_reset");
    rst = 1'b0;
    chk("mid_reset_state", st, 0);
    chk("mid_reset_progress", prog, 0);
    chk("mid_reset_out7", o7, 0);

    // Collision on the same cycle as a step tick.
    press("arm2");
    tick_once("arm2_tick", 2'd0);
    for (int i = 0; i < 7; i++) tick_once("pre_coll", 2'd2);
    rnd = 2'd2; tick = 1'b1; coll = 1'b1;
    cycle("coll_step");
    tick = 1'b0; coll = 1'b0;
    chk("coll_state", st, 3);
    chk("coll_progress", prog, 1);
    chk("coll_out1", o1, 3);
    tick_once("blink", 2'd0);
    chk("blink_still_on", o4, 3);
    tick_once("blink", 2'd0);
    chk("blink_off", o4, 0);
    tick_once("blink", 2'd0);
    tick_once("blink", 2'd0);
    chk("blink_on_again", o4, 3);

    // Collision ignored in IDLE, ARM and WIN; full level reaches WIN.
    press("over_exit");
    chk("over_exit_state", st, 0);
    coll = 1'b1; cycle("coll_idle"); coll = 1'b0;
    chk("coll_idle_state", st, 0);
    press("arm3");
    coll = 1'b1; cycle("coll_arm"); coll = 1'b0;
    chk("coll_arm_state", st, 1);
    tick_once("arm3_tick", 2'd0);
    for (int i = 0; i < 64; i++) tick_once("level", 2'($urandom));
    cycle("win_settle");
    chk("win_state", st, 4);
    chk("win_progress", prog, 16);
    chk("win_out1", o1, 1);
    chk("win_out7", o7, 1);
    coll = 1'b1; cycle("coll_win"); coll = 1'b0;
    chk("coll_win_state", st, 4);
    press("win_exit");
    chk("win_exit_state", st, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      start_n = ($urandom_range(0, 9) != 0);
      tick    = $urandom_range(0, 1) == 1;
      coll    = ($urandom_range(0, 79) == 0);
      rnd     = 2'($urandom);
      cycle("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sc_road_sequencer
`default_nettype wire
